// File: rtl/undet_pkg.sv
// Shared defaults and token types for the undet_sched round-robin scheduler.
package undet_pkg;
  localparam int W_DEF    = 8;
  localparam int NREQ_DEF = 4;
  localparam int LAT_DEF  = 3;
  localparam int ID_W     = $clog2(NREQ_DEF);

  typedef logic [ID_W-1:0] id_t;

  typedef struct packed {
    logic v;
    id_t  id;
  } tok_t;
endpackage

// File: rtl/undet_sched_if.sv
// Requester and response channels of undet_sched.
// Handshake: a transfer happens at a rising edge where valid and ready are both
// high; the producer holds data stable while valid is high and ready is low.
interface undet_sched_if #(
  parameter int W    = undet_pkg::W_DEF,
  parameter int NREQ = undet_pkg::NREQ_DEF
) ();
  logic [NREQ-1:0]         req_valid;
  logic [NREQ*W-1:0]       req_data;
  logic [NREQ-1:0]         req_ready;
  logic                    resp_valid;
  logic                    resp_ready;
  logic [$clog2(NREQ)-1:0] resp_id;
  logic [W-1:0]            resp_data;

  modport master (
    output req_valid, req_data, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_data
  );

  modport slave (
    input  req_valid, req_data, resp_ready,
    output req_ready, resp_valid, resp_id, resp_data
  );
endinterface

// File: rtl/undet_rr_arb.sv
// Rotating-priority arbiter: searches from ptr upward (mod N), grants only when
// the caller says the pipeline advances, and moves ptr past the winner.
module undet_rr_arb import undet_pkg::*; #(
  parameter int N = NREQ_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         valid,
  input  logic                 advance,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);
  localparam int IDW = $clog2(N);

  logic [IDW-1:0] ptr;
  logic           found;
  int             cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    // Walk offsets from farthest to nearest so the nearest valid one wins.
    for (int k = N - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (valid[IDW'(cand)]) begin
        idx   = IDW'(cand);
        found = 1'b1;
      end
    end
    any = found & advance;
    if (any) grant[idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr <= '0;
    end else if (any) begin
      ptr <= (idx == IDW'(N - 1)) ? '0 : idx + 1'b1;
    end
  end
endmodule

// File: rtl/undet_sched.sv
// Shares an enable-gated datapath among NREQ requesters; a token pipeline of
// LAT stages tags each issued operand so its r3 result returns with its id.
module undet_sched import undet_pkg::*; #(
  parameter int W    = W_DEF,
  parameter int NREQ = NREQ_DEF,
  parameter int LAT  = LAT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  undet_sched_if.slave bus,
  output logic [W-1:0] dp_d,
  output logic         dp_en,
  input  logic [W-1:0] dp_r3,
  output logic         busy
);
  localparam int IDW = $clog2(NREQ);

  tok_t            pipe [LAT];
  logic            stall;
  logic            advance;
  logic            any;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  idx;

  // A held response freezes tokens, pointer and datapath together.
  assign stall   = pipe[LAT-1].v & ~bus.resp_ready;
  assign advance = ~stall & rst;

  undet_rr_arb #(.N(NREQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   (bus.req_valid),
    .advance (advance),
    .grant   (grant),
    .idx     (idx),
    .any     (any)
  );

  assign bus.req_ready  = grant;
  assign dp_en          = advance;
  assign dp_d           = any ? bus.req_data[idx*W +: W] : '0;
  assign bus.resp_valid = pipe[LAT-1].v;
  assign bus.resp_id    = pipe[LAT-1].id;
  assign bus.resp_data  = dp_r3;

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < LAT; k++) busy = busy | pipe[k].v;
  end

  // Bubbles carry id 0 so resp_id reads 0 whenever nothing is valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < LAT; k++) pipe[k] <= '0;
    end else if (advance) begin
      pipe[0].v  <= any;
      pipe[0].id <= any ? id_t'(idx) : id_t'(0);
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
  end
endmodule

// File: tb/tb_undet_sched.sv
// Bench for undet_sched: local enable-gated datapath, queue-based reference
// model of arbitration and response ordering, directed and random traffic.
module tb_undet_sched;
  localparam int W    = 8;
  localparam int NREQ = 4;
  localparam int LAT  = 3;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  undet_sched_if #(.W(W), .NREQ(NREQ)) bus ();

  logic [W-1:0] dp_d;
  logic         dp_en;
  logic [W-1:0] dp_r3;
  logic         busy;

  undet_sched #(.W(W), .NREQ(NREQ), .LAT(LAT)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .dp_d  (dp_d),
    .dp_en (dp_en),
    .dp_r3 (dp_r3),
    .busy  (busy)
  );

  // Datapath instance: d -> r0/r1 -> r2 -> r3, all regs gated by dp_en.
  logic [W-1:0] r0, r1, r2, r3;
  always_ff @(posedge clk) begin
    if (dp_en) begin
      r0 <= dp_d + 8'h35;
      r1 <= {dp_d[6:0], dp_d[7]} ^ 8'hA6;
      r2 <= r0 + r1;
      r3 <= r2 ^ {r2[3:0], r2[7:4]};
    end
  end
  assign dp_r3 = r3;

  function automatic logic [W-1:0] dp_ref(input logic [W-1:0] d);
    logic [W-1:0] a, b, c;
    a = d + 8'h35;
    b = {d[6:0], d[7]} ^ 8'hA6;
    c = a + b;
    return c ^ {c[3:0], c[7:4]};
  endfunction

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  int           exp_id_q[$];
  int           cnt_q[$];  // advancing edges left before the result is at r3
  int           mptr = 0;
  logic         prev_rst = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge; returns just after the next falling edge.
  task automatic cycle(input logic rstv, input logic [NREQ-1:0] v,
                       input logic [NREQ*W-1:0] d, input logic rr);
    logic            head_v, stall, adv, skip;
    logic [NREQ-1:0] er;
    int              g;
    rst            = rstv;
    bus.req_valid  = v;
    bus.req_data   = d;
    bus.resp_ready = rr;
    #1;
    head_v = (cnt_q.size() > 0) && (cnt_q[0] == 0);
    stall  = head_v && !rr;
    adv    = rstv && !stall;
    skip   = !rstv && prev_rst;  // reset not yet taken by any edge
    g = -1;
    er = '0;
    if (adv) begin
      for (int k = 0; k < NREQ; k++) begin
        if (g < 0 && v[(mptr + k) % NREQ]) g = (mptr + k) % NREQ;
      end
    end
    if (g >= 0) er[g] = 1'b1;

    chk("req_ready", 32'(bus.req_ready), 32'(er));
    chk("dp_en", 32'(dp_en), 32'(adv));
    chk("dp_d", 32'(dp_d), (g >= 0) ? 32'(d[g*W +: W]) : 32'd0);
    if (!skip) begin
      chk("resp_valid", 32'(bus.resp_valid), 32'(head_v));
      chk("busy", 32'(busy), 32'(exp_q.size() > 0));
      chk("resp_id", 32'(bus.resp_id), head_v ? 32'(exp_id_q[0]) : 32'd0);
      if (head_v) chk("resp_data", 32'(bus.resp_data), 32'(exp_q[0]));
    end

    @(posedge clk);
    if (!rstv) begin
      exp_q.delete();
      exp_id_q.delete();
      cnt_q.delete();
      mptr = 0;
    end else if (adv) begin
      if (head_v && rr) begin
        void'(exp_q.pop_front());
        void'(exp_id_q.pop_front());
        void'(cnt_q.pop_front());
      end
      foreach (cnt_q[i]) if (cnt_q[i] > 0) cnt_q[i] = cnt_q[i] - 1;
      if (g >= 0) begin
        exp_q.push_back(dp_ref(d[g*W +: W]));
        exp_id_q.push_back(g);
        cnt_q.push_back(LAT - 1);
        mptr = (g + 1) % NREQ;
      end
    end
    prev_rst = rstv;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) cycle(1'b1, '0, '0, rr);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) idle(1, 1'b1);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [NREQ*W-1:0] rand_data();
    return {$urandom, $urandom} >> (64 - NREQ*W);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst            = 1'b0;
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.resp_ready = 1'b0;
    @(negedge clk);

    // Reset state
    cycle(1'b0, '0, '0, 1'b1);
    cycle(1'b0, 4'hF, rand_data(), 1'b1);

    // Single request: requester 2 sends 8'h10
    cycle(1'b1, 4'b0100, {8'h00, 8'h10, 8'h00, 8'h00}, 1'b1);
    idle(5, 1'b1);

    // All four valid continuously from ptr=0
    cycle(1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 12; i++) cycle(1'b1, 4'hF, rand_data(), 1'b1);
    drain();

    // Three tokens in flight, then resp_ready low for 5 cycles with requests pending
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'hF, rand_data(), 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 4'hF, rand_data(), 1'b0);
    drain();

    // Requester 1 for two cycles, then requester 3
    cycle(1'b1, 4'b0010, rand_data(), 1'b1);
    cycle(1'b1, 4'b0010, rand_data(), 1'b1);
    cycle(1'b1, 4'b1000, rand_data(), 1'b1);
    cycle(1'b1, 4'b1000, rand_data(), 1'b1);
    drain();

    // Reset with two tokens in flight
    cycle(1'b1, 4'b0100, rand_data(), 1'b1);
    cycle(1'b1, 4'b1000, rand_data(), 1'b1);
    cycle(1'b0, 4'hF, rand_data(), 1'b1);
    idle(4, 1'b1);
    cycle(1'b1, 4'hF, rand_data(), 1'b1);
    drain();

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      cycle(($urandom_range(0, 99) != 0), 4'($urandom_range(0, 15)), rand_data(),
            ($urandom_range(0, 3) != 0));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/undet_sched.md
# undet_sched

Round-robin scheduler that shares the 8-bit undetermined-function datapath (d → r0/r1 → r2 → r3 chain) among several requesters. It arbitrates one operand per cycle onto the datapath `d` input and gates datapath advance with a global enable. It tracks each issued operand through a token pipeline, then returns the sampled `r3` value to the requester with its id on a valid/ready response channel. It sits between the requester fabric and an enable-gated instance of the datapath.

## Interface
- `W`, 8, datapath and operand width
- `NREQ`, 4, number of requesters (≥2)
- `LAT`, 3, cycles from operand on `dp_d` to its result on `dp_r3` with `dp_en` held high
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, synchronous, active-low
- `req_valid`  in  NREQ  per-requester operand valid
- `req_data`  in  NREQ*W  operands; requester i in bits [i*W +: W]
- `req_ready`  out  NREQ  one-hot-or-zero grant; transfer when valid&ready at the edge
- `dp_d`  out  W  operand to datapath `d`
- `dp_en`  out  1  datapath register enable (all datapath regs update only when high)
- `dp_r3`  in  W  datapath `r3` value
- `resp_valid`  out  1  result available
- `resp_ready`  in  1  consumer accepts result
- `resp_id`  out  clog2(NREQ)  requester index of result
- `resp_data`  out  W  result value
- `busy`  out  1  any token in flight

## Operation
- Token pipeline: `LAT` stages, each {v, id}. Stage 0 loads on an advancing edge; stage k loads from stage k-1.
- `stall` = `resp_valid` & !`resp_ready`. `dp_en` = !`stall` & `rst`. On a stalled edge, tokens, pointer and datapath all hold.
- Arbiter: rotating pointer `ptr`. Grant goes to the first i with `req_valid[i]`, searching ptr, ptr+1, … mod NREQ. The grant is asserted on `req_ready` only when !`stall`. `req_ready` is 0 for all requesters during stall and during reset.
- After a grant to g, `ptr` becomes (g+1) mod NREQ. `ptr` is unchanged when there is no grant.
- On an advancing edge with a grant: `dp_d` = `req_data[g]` and stage 0 gets {1, g}. Without a grant: `dp_d` = 0 and stage 0 gets {0, x} (a bubble). The datapath still advances.
- `resp_valid` = last-stage v. `resp_id` = last-stage id. `resp_data` = `dp_r3` (combinational passthrough, stable while stalled because the datapath is frozen).
- A response transfers on `resp_valid` & `resp_ready`. The same edge advances the pipeline, so a back-to-back response is possible in the next cycle.
- `busy` = OR of all stage v.
- Reset (rst=0 at an edge) has these effects:
  - All v cleared and `ptr`=0.
  - Outputs `req_ready`=0, `resp_valid`=0, `resp_id`=0, `dp_en`=0, `dp_d`=0, `busy`=0.
  - Reset mid-operation discards in-flight tokens with no response. Datapath contents after reset are don't-care, because bubbles are never reported.

## Timing
- Latency: a grant at edge t produces `resp_valid`=1 in the cycle after edge t+LAT-1 (i.e. after LAT advancing edges), plus one cycle per stalled edge.
- Throughput: one grant and one response per cycle with `resp_ready` held high.
- Simultaneous events:
  - All requesters valid: grants rotate in strict order ptr, ptr+1, ….
  - Response accept and new grant on the same edge: both happen.
  - Stall with `req_valid` high: no grant, and `ptr` is frozen.
- Requesters may drop `req_valid` without being granted; the arbiter does not lock.

## Structure
- Package `undet_pkg`: defaults for `W`/`NREQ`/`LAT`, `id_t` = logic[clog2(NREQ)-1:0], and `tok_t` struct {v, id}.
- Sub-module `undet_rr_arb` holds the combinational rotating-priority pick plus the `ptr` register, with inputs valid/advance and outputs grant one-hot plus index. The token pipeline and response logic stay in the top level.

## Test plan
- Single request: requester 2 sends 8'h10 at cycle 1 with `resp_ready`=1 → `resp_valid` at cycle 4, `resp_id`=2, `resp_data`=`dp_r3` from the reference datapath model; `busy` high for cycles 2–4.
- All four valid continuously, ptr=0 → grants 0,1,2,3,0,… one per cycle; responses return ids 0,1,2,3 in order, one per cycle.
- `resp_ready`=0 for 5 cycles with 3 tokens in flight → `dp_en`=0, `req_ready`=0, `resp_data` stable. After release, the 3 responses arrive on consecutive cycles with no loss or duplication.
- Requester 1 only valid for 2 cycles, then requester 3 → bubbles are never reported, and `ptr` follows 2 then 0.
- Assert `rst`=0 with 2 tokens in flight → next cycle `resp_valid`=0, `busy`=0, `ptr`=0; no stale response after reset release.
- Randomized requests and `resp_ready` against a scoreboard tracking the datapath model → every granted operand gets exactly one response with the correct id and value.
